// File: rtl/param_bcd_countdown_timer_if.sv
// rtl/param_bcd_countdown_timer_if.sv - control and status bundle for the BCD countdown timer
//
// Signals:
//   tick                     time-base pulse, one clk wide
//   load, load_min10..sec1   load strobe and BCD load digits
//   start, pause, clear      run control
//   auto_reload              reload on expiry and keep running
//   min10, min1, sec10, sec1 current BCD count (registered)
//   running, expired         state decodes (RUN, DONE)
//   done_pulse               one-clk pulse on each expiry
// Modports: master drives controls and observes status; slave is the timer.
interface param_bcd_countdown_timer_if;
    logic       tick;
    logic       load;
    logic [3:0] load_min10;
    logic [3:0] load_min1;
    logic [3:0] load_sec10;
    logic [3:0] load_sec1;
    logic       start;
    logic       pause;
    logic       clear;
    logic       auto_reload;
    logic [3:0] min10;
    logic [3:0] min1;
    logic [3:0] sec10;
    logic [3:0] sec1;
    logic       running;
    logic       done_pulse;
    logic       expired;

    modport master (
        output tick, load, load_min10, load_min1, load_sec10, load_sec1,
        output start, pause, clear, auto_reload,
        input  min10, min1, sec10, sec1, running, done_pulse, expired
    );

    modport slave (
        input  tick, load, load_min10, load_min1, load_sec10, load_sec1,
        input  start, pause, clear, auto_reload,
        output min10, min1, sec10, sec1, running, done_pulse, expired
    );
endinterface

// File: rtl/param_bcd_countdown_timer.sv
// rtl/param_bcd_countdown_timer.sv - MM:SS BCD countdown timer with prescaler and auto-reload
//
// Parameters:
//   MIN10_MAX  largest legal minutes-tens digit (1..9)
//   TICK_DIV   tick pulses per counted second (>=1)
// Ports:
//   clk        clock, rising edge
//   reset_p    asynchronous active-high reset
//   bus        slave side of param_bcd_countdown_timer_if (controls in, count/status out)
// Control priority each clock: clear > load > start > pause > tick.
module param_bcd_countdown_timer #(
    parameter int MIN10_MAX = 9,
    parameter int TICK_DIV  = 1
) (
    input  logic                        clk,
    input  logic                        reset_p,
    param_bcd_countdown_timer_if.slave  bus
);

    localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]     MIN10_LIM  = 4'(MIN10_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    // Counts are packed {min10, min1, sec10, sec1}.
    logic [15:0]   count_q, count_d;
    logic [15:0]   reload_q, reload_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;
    logic [15:0]   load_val;
    logic          count_zero;
    logic          reload_zero;

    function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // One-second BCD decrement with borrow; never applied to 00:00.
    function automatic logic [15:0] bcd_dec(input logic [15:0] c);
        logic [3:0] m10, m1, s10, s1;
        {m10, m1, s10, s1} = c;
        if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
        end else begin
            s1 = 4'd9;
            if (s10 != 4'd0) begin
                s10 = s10 - 4'd1;
            end else begin
                s10 = 4'd5;
                if (m1 != 4'd0) begin
                    m1 = m1 - 4'd1;
                end else begin
                    m1  = 4'd9;
                    m10 = m10 - 4'd1;
                end
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    always_comb begin
        load_val    = {clamp(bus.load_min10, MIN10_LIM), clamp(bus.load_min1, 4'd9),
                       clamp(bus.load_sec10, 4'd5), clamp(bus.load_sec1, 4'd9)};
        count_zero  = (count_q == 16'h0000);
        reload_zero = (reload_q == 16'h0000);

        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        done_d   = 1'b0;

        if (bus.clear) begin
            count_d = 16'h0000;
            presc_d = '0;
            state_d = IDLE;
        end else if (bus.load) begin
            count_d  = load_val;
            reload_d = load_val;
            presc_d  = '0;
            state_d  = IDLE;
        end else if (bus.start && state_q != RUN) begin
            // A start that applies here consumes the cycle, so a same-cycle tick is dropped.
            case (state_q)
                IDLE, PAUSE: begin
                    if (!count_zero) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    count_d = reload_q;
                    presc_d = '0;
                    state_d = reload_zero ? IDLE : RUN;
                end
                default: ;
            endcase
        end else if (bus.pause && state_q == RUN) begin
            state_d = PAUSE;
        end else if (bus.tick && state_q == RUN) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                if (count_zero) begin
                    // Sitting at 00:00 in RUN only happens after an auto-reload expiry.
                    count_d = reload_q;
                end else begin
                    count_d = bcd_dec(count_q);
                    if (count_q == 16'h0001) begin
                        done_d = 1'b1;
                        if (!(bus.auto_reload && !reload_zero)) begin
                            state_d = DONE;
                        end
                    end
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q  <= IDLE;
            count_q  <= 16'h0000;
            reload_q <= 16'h0000;
            presc_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            done_q   <= done_d;
        end
    end

    assign bus.min10      = count_q[15:12];
    assign bus.min1       = count_q[11:8];
    assign bus.sec10      = count_q[7:4];
    assign bus.sec1       = count_q[3:0];
    assign bus.running    = (state_q == RUN);
    assign bus.expired    = (state_q == DONE);
    assign bus.done_pulse = done_q;

endmodule

// File: tb/tb_param_bcd_countdown_timer.sv
// tb/tb_param_bcd_countdown_timer.sv - directed bench for param_bcd_countdown_timer
module tb_param_bcd_countdown_timer;

    logic clk = 1'b0;
    logic reset_p;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    param_bcd_countdown_timer_if ifa ();
    param_bcd_countdown_timer_if ifb ();

    param_bcd_countdown_timer #(.MIN10_MAX(9), .TICK_DIV(1)) dut_a (
        .clk     (clk),
        .reset_p (reset_p),
        .bus     (ifa)
    );

    param_bcd_countdown_timer #(.MIN10_MAX(5), .TICK_DIV(3)) dut_b (
        .clk     (clk),
        .reset_p (reset_p),
        .bus     (ifb)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] cnt_a();
        return {ifa.min10, ifa.min1, ifa.sec10, ifa.sec1};
    endfunction

    function automatic logic [15:0] cnt_b();
        return {ifb.min10, ifb.min1, ifb.sec10, ifb.sec1};
    endfunction

    function automatic logic [15:0] stat_a();
        return {13'd0, ifa.running, ifa.done_pulse, ifa.expired};
    endfunction

    function automatic logic [15:0] stat_b();
        return {13'd0, ifb.running, ifb.done_pulse, ifb.expired};
    endfunction

    task automatic load_a(input logic [15:0] v);
        {ifa.load_min10, ifa.load_min1, ifa.load_sec10, ifa.load_sec1} = v;
        ifa.load = 1'b1;
        cyc();
        ifa.load = 1'b0;
    endtask

    task automatic load_b(input logic [15:0] v);
        {ifb.load_min10, ifb.load_min1, ifb.load_sec10, ifb.load_sec1} = v;
        ifb.load = 1'b1;
        cyc();
        ifb.load = 1'b0;
    endtask

    task automatic start_a();
        ifa.start = 1'b1;
        cyc();
        ifa.start = 1'b0;
    endtask

    // status encoding: {running, done_pulse, expired}
    initial begin
        reset_p = 1'b1;
        {ifa.tick, ifa.load, ifa.start, ifa.pause, ifa.clear, ifa.auto_reload} = '0;
        {ifa.load_min10, ifa.load_min1, ifa.load_sec10, ifa.load_sec1} = '0;
        {ifb.tick, ifb.load, ifb.start, ifb.pause, ifb.clear, ifb.auto_reload} = '0;
        {ifb.load_min10, ifb.load_min1, ifb.load_sec10, ifb.load_sec1} = '0;

        // Reset before any clock edge
        #3;
        chk("rst_cnt", cnt_a(), 16'h0000);
        chk("rst_stat", stat_a(), 16'h0000);
        @(negedge clk);
        reset_p = 1'b0;

        // 00:03 countdown to expiry
        load_a(16'h0003);
        chk("ld3_cnt", cnt_a(), 16'h0003);
        chk("ld3_stat", stat_a(), 16'h0000);
        start_a();
        chk("st3_stat", stat_a(), 16'h0004);
        ifa.tick = 1'b1;
        cyc();
        chk("t1_cnt", cnt_a(), 16'h0002);
        cyc();
        chk("t2_cnt", cnt_a(), 16'h0001);
        cyc();
        chk("t3_cnt", cnt_a(), 16'h0000);
        chk("t3_stat", stat_a(), 16'h0003);
        cyc();
        chk("t4_cnt", cnt_a(), 16'h0000);
        chk("t4_stat", stat_a(), 16'h0001);
        ifa.tick = 1'b0;
        // start in DONE reloads 00:03
        start_a();
        chk("rl_cnt", cnt_a(), 16'h0003);
        chk("rl_stat", stat_a(), 16'h0004);
        ifa.clear = 1'b1;
        cyc();
        ifa.clear = 1'b0;
        chk("clr_cnt", cnt_a(), 16'h0000);
        chk("clr_stat", stat_a(), 16'h0000);

        // Borrow chains
        load_a(16'h0100);
        start_a();
        ifa.tick = 1'b1;
        cyc();
        ifa.tick = 1'b0;
        chk("b0100", cnt_a(), 16'h0059);
        load_a(16'h1000);
        start_a();
        ifa.tick = 1'b1;
        cyc();
        ifa.tick = 1'b0;
        chk("b1000", cnt_a(), 16'h0959);

        // Auto-reload
        ifa.auto_reload = 1'b1;
        load_a(16'h0002);
        start_a();
        ifa.tick = 1'b1;
        cyc();
        chk("ar1_cnt", cnt_a(), 16'h0001);
        chk("ar1_stat", stat_a(), 16'h0004);
        cyc();
        chk("ar2_cnt", cnt_a(), 16'h0000);
        chk("ar2_stat", stat_a(), 16'h0006);
        cyc();
        chk("ar3_cnt", cnt_a(), 16'h0002);
        chk("ar3_stat", stat_a(), 16'h0004);
        cyc();
        chk("ar4_cnt", cnt_a(), 16'h0001);
        chk("ar4_stat", stat_a(), 16'h0004);
        ifa.tick = 1'b0;
        ifa.auto_reload = 1'b0;

        // Clamping
        load_a(16'hC79F);
        chk("clamp_a", cnt_a(), 16'h9759);
        load_b(16'hC79F);
        chk("clamp_b", cnt_b(), 16'h5759);

        // Pause, then resume with a same-cycle tick
        load_a(16'h0005);
        start_a();
        ifa.pause = 1'b1;
        cyc();
        ifa.pause = 1'b0;
        chk("ps_stat", stat_a(), 16'h0000);
        ifa.tick = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("ps_cnt", cnt_a(), 16'h0005);
        ifa.start = 1'b1;
        cyc();
        ifa.start = 1'b0;
        chk("rs_cnt", cnt_a(), 16'h0005);
        chk("rs_stat", stat_a(), 16'h0004);
        cyc();
        ifa.tick = 1'b0;
        chk("rs_tick", cnt_a(), 16'h0004);

        // clear and load together
        {ifa.load_min10, ifa.load_min1, ifa.load_sec10, ifa.load_sec1} = 16'h0305;
        ifa.clear = 1'b1;
        ifa.load  = 1'b1;
        cyc();
        ifa.clear = 1'b0;
        ifa.load  = 1'b0;
        chk("cl_cnt", cnt_a(), 16'h0000);
        chk("cl_stat", stat_a(), 16'h0000);
        // start at 00:00 ignored
        start_a();
        chk("s0_cnt", cnt_a(), 16'h0000);
        chk("s0_stat", stat_a(), 16'h0000);

        // Reset mid-count
        load_a(16'h0020);
        start_a();
        ifa.tick = 1'b1;
        cyc();
        cyc();
        chk("pre_rst", cnt_a(), 16'h0018);
        reset_p = 1'b1;
        #2;
        chk("arst_cnt", cnt_a(), 16'h0000);
        chk("arst_stat", stat_a(), 16'h0000);
        cyc();
        chk("hrst_stat", stat_a(), 16'h0000);
        ifa.tick = 1'b0;
        reset_p = 1'b0;
        cyc();
        chk("post_cnt", cnt_a(), 16'h0000);
        chk("post_stat", stat_a(), 16'h0000);

        // TICK_DIV=3 on dut_b
        load_b(16'h0002);
        ifb.start = 1'b1;
        cyc();
        ifb.start = 1'b0;
        chk("d3_run", stat_b(), 16'h0004);
        ifb.tick = 1'b1;
        cyc();
        chk("d3_t1", cnt_b(), 16'h0002);
        cyc();
        chk("d3_t2", cnt_b(), 16'h0002);
        cyc();
        chk("d3_t3", cnt_b(), 16'h0001);
        cyc();
        cyc();
        chk("d3_t5", cnt_b(), 16'h0001);
        cyc();
        ifb.tick = 1'b0;
        chk("d3_t6", cnt_b(), 16'h0000);
        chk("d3_stat", stat_b(), 16'h0003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/param_bcd_countdown_timer.md
PARAM_BCD_COUNTDOWN_TIMER -- requirements
Module: param_bcd_countdown_timer

Interface
REQ-001 Parameter MIN10_MAX, default 9: maximum legal minutes-tens digit (range 1..9).
REQ-002 Parameter TICK_DIV, default 1: number of tick pulses per counted second (>=1).
REQ-003 Port clk, input, 1: clock; all state changes on its rising edge.
REQ-004 Port reset_p, input, 1: reset; asynchronous, active-high.
REQ-005 Port tick, input, 1: one-clk-wide time-base pulse.
REQ-006 Port load, input, 1: capture load_* digits as count and reload value.
REQ-007 Port load_min10, load_min1, load_sec10, load_sec1, inputs, 4 each: BCD load digits.
REQ-008 Port start, input, 1: begin or resume counting.
REQ-009 Port pause, input, 1: suspend counting.
REQ-010 Port clear, input, 1: abort and zero the count.
REQ-011 Port auto_reload, input, 1: when high, reload on expiry and keep running.
REQ-012 Port min10, min1, sec10, sec1, outputs, 4 each: current BCD count (registered).
REQ-013 Port running, output, 1: high in RUN state.
REQ-014 Port done_pulse, output, 1: one-clk pulse on each expiry.
REQ-015 Port expired, output, 1: level, high in DONE state.

Function
REQ-016 The block SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-017 Control priority SHALL be clear > load > start > pause > tick, evaluated once per clock.
REQ-018 clear, in any state: all four digits 0, prescaler 0, state IDLE; the stored reload value is kept.
REQ-019 load, in any state: digits and reload register take the load values; prescaler 0; state IDLE.
REQ-020 Load clamping: any digit >9 becomes 9; sec10 >5 becomes 5; min10 >MIN10_MAX becomes MIN10_MAX.
REQ-021 start, in IDLE or PAUSE with a nonzero count: go to RUN; a tick in the same cycle is ignored.
REQ-022 start with a count of 00:00 SHALL be ignored; state is unchanged.
REQ-023 start, in DONE: reload the stored value; go to RUN if it is nonzero, else go to IDLE.
REQ-024 pause, in RUN: go to PAUSE; digits and prescaler hold. In other states pause is ignored.
REQ-025 Prescaler, in RUN: counts ticks 0..TICK_DIV-1; the tick that wraps it to 0 SHALL produce one decrement.
REQ-026 Decrement, registered on the same edge as the qualifying tick:
- sec1 borrows from 0 to 9.
- sec10 borrows from 0 to 5.
- min1 borrows from 0 to 9.
- min10 decrements by 1.
REQ-027 Expiry: a decrement that produces 00:00 SHALL assert done_pulse for exactly the next clock, registered on the same edge as the zero digits.
REQ-028 Expiry with auto_reload=1: on the following qualifying tick the digits SHALL load the reload value, with no decrement on that tick; state stays RUN.
REQ-029 Expiry with auto_reload=0: state goes to DONE on the same edge; digits hold 00:00; expired=1 until clear, load or start.
REQ-030 Expiry with auto_reload=1 and a reload value of 00:00 SHALL behave as auto_reload=0.
REQ-031 Digits SHALL never show a non-BCD value or sec10 >5; count never wraps below 00:00.
REQ-032 Outputs are registered; running and expired are decoded from the state register; there is no combinational input-to-output path.
REQ-033 Maximum count is MIN10_MAX,9:5,9, i.e. 99:59 at defaults.

Reset
REQ-034 While reset_p is high, all of the following SHALL hold immediately, independent of clk:
- digits 0, reload register 0, prescaler 0
- state IDLE
- running=0, done_pulse=0, expired=0
REQ-035 Reset asserted mid-RUN SHALL abort the count with no done_pulse generated.
REQ-036 The first clock edge after reset_p deasserts SHALL obey the normal priority rules.

Verification
REQ-037 Load 00:03, start, 3 ticks (TICK_DIV=1) -> count 02, 01, 00; done_pulse single cycle with 00; running=0, expired=1.
REQ-038 Load 01:00, start, 1 tick -> 00:59; load 10:00, 1 tick -> 09:59 (full borrow chain).
REQ-039 Load 00:02, auto_reload=1, start, 4 ticks -> 01, 00 with done_pulse, 02 (reload), 01; running stays 1.
REQ-040 Load digits 0xC,0x7,0x9,0xF -> clamped to 9,7:5,9 at defaults; with MIN10_MAX=5 -> 5,7:5,9.
REQ-041 Pause during RUN at 00:05, 3 ticks -> holds 00:05; start and tick same cycle -> still 00:05, next tick -> 00:04.
REQ-042 Edge cases:
- clear and load together -> 00:00 in IDLE.
- start at 00:00 -> stays IDLE.
- reset_p pulsed mid-count -> all outputs 0 with no done_pulse.
- TICK_DIV=3 -> one decrement per 3 ticks.
